// File: rtl/tpx3_tx_emu_if.sv
// Packet handshake between a Timepix3 packet source (master) and tpx3_tx_emu (slave).
interface tpx3_tx_emu_if;
  logic [47:0] PKT_DATA;
  logic        PKT_VALID;
  logic        PKT_READY;

  modport master (output PKT_DATA, output PKT_VALID, input PKT_READY);
  modport slave  (input PKT_DATA, input PKT_VALID, output PKT_READY);
endinterface

// File: rtl/tpx3_tx_emu.sv
// Timepix3 serial link emulator: 48-bit packets -> 8b10b symbols, one bit per clock, K28.5 between packets.
// Optional macro TPX3_TX_ERR_INJ_EN adds INJECT_ERR, which flips bit a of the next data symbol on the line.
module tpx3_tx_emu #(
  parameter int IDLE_GAP      = 1,
  parameter int PKT_CNT_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ENABLE,
  tpx3_tx_emu_if.slave             pkt,
  output logic                     TX_DATA,
  output logic                     BUSY,
  output logic [PKT_CNT_WIDTH-1:0] PKT_CNT
`ifdef TPX3_TX_ERR_INJ_EN
  ,
  input  logic                     INJECT_ERR
`endif
);
  localparam logic [9:0] K28_5_NEG = 10'b0011111010;
  localparam logic [9:0] K28_5_POS = 10'b1100000101;
  localparam bit         HAS_GAP   = (IDLE_GAP > 0);
  localparam logic [3:0] GAP_LAST  = HAS_GAP ? 4'(IDLE_GAP - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_GAP} state_t;

  state_t                   r_state;
  logic [3:0]               r_bit_cnt;
  logic [2:0]               r_byte_idx;
  logic [3:0]               r_gap_cnt;
  logic [47:0]              r_pkt;
  logic [9:0]               r_shift;
  logic                     r_rd;
  logic                     r_flip;
  logic                     r_busy;
  logic [PKT_CNT_WIDTH-1:0] r_cnt;

  // Returns {disparity flips, abcdei fghj}. Table entries carry a "complement under RD+" flag.
  function automatic logic [10:0] enc_8b10b(input logic [7:0] d, input logic k, input logic rd);
    logic [6:0] t6;
    logic [4:0] t4;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       flip6, flip4, rd6, a7;
    if (k) return {1'b1, rd ? K28_5_POS : K28_5_NEG};
    case (d[4:0])
      5'd0:  t6 = 7'b1_100111;  5'd1:  t6 = 7'b1_011101;
      5'd2:  t6 = 7'b1_101101;  5'd3:  t6 = 7'b0_110001;
      5'd4:  t6 = 7'b1_110101;  5'd5:  t6 = 7'b0_101001;
      5'd6:  t6 = 7'b0_011001;  5'd7:  t6 = 7'b1_111000;
      5'd8:  t6 = 7'b1_111001;  5'd9:  t6 = 7'b0_100101;
      5'd10: t6 = 7'b0_010101;  5'd11: t6 = 7'b0_110100;
      5'd12: t6 = 7'b0_001101;  5'd13: t6 = 7'b0_101100;
      5'd14: t6 = 7'b0_011100;  5'd15: t6 = 7'b1_010111;
      5'd16: t6 = 7'b1_011011;  5'd17: t6 = 7'b0_100011;
      5'd18: t6 = 7'b0_010011;  5'd19: t6 = 7'b0_110010;
      5'd20: t6 = 7'b0_001011;  5'd21: t6 = 7'b0_101010;
      5'd22: t6 = 7'b0_011010;  5'd23: t6 = 7'b1_111010;
      5'd24: t6 = 7'b1_110011;  5'd25: t6 = 7'b0_100110;
      5'd26: t6 = 7'b0_010110;  5'd27: t6 = 7'b1_110110;
      5'd28: t6 = 7'b0_001110;  5'd29: t6 = 7'b1_101110;
      5'd30: t6 = 7'b1_011110;  default: t6 = 7'b1_101011;
    endcase
    // D.07 swaps form under RD+ but is balanced, so it never flips disparity
    flip6 = t6[6] && (d[4:0] != 5'd7);
    c6    = (rd && t6[6]) ? ~t6[5:0] : t6[5:0];
    rd6   = rd ^ flip6;
    a7    = rd6 ? (d[4:0] == 5'd11 || d[4:0] == 5'd13 || d[4:0] == 5'd14)
                : (d[4:0] == 5'd17 || d[4:0] == 5'd18 || d[4:0] == 5'd20);
    case (d[7:5])
      3'd0:    t4 = 5'b1_1011;
      3'd1:    t4 = 5'b0_1001;
      3'd2:    t4 = 5'b0_0101;
      3'd3:    t4 = 5'b1_1100;
      3'd4:    t4 = 5'b1_1101;
      3'd5:    t4 = 5'b0_1010;
      3'd6:    t4 = 5'b0_0110;
      default: t4 = a7 ? 5'b1_0111 : 5'b1_1110;
    endcase
    flip4 = t4[4] && (d[7:5] != 3'd3);
    c4    = (rd6 && t4[4]) ? ~t4[3:0] : t4[3:0];
    return {flip6 ^ flip4, c6, c4};
  endfunction

  logic        w_bnd, w_gap_last, w_ready, w_take, w_sym_k;
  logic [7:0]  w_byte;
  logic [10:0] w_enc;
  logic [9:0]  w_line;

  assign w_bnd      = (r_bit_cnt == 4'd9);
  assign w_gap_last = HAS_GAP && (r_gap_cnt == GAP_LAST);
  assign w_ready    = !RST && w_bnd && ENABLE &&
                      (r_state == S_IDLE ||
                       (r_state == S_DATA && r_byte_idx == 3'd5 && !HAS_GAP) ||
                       (r_state == S_GAP && w_gap_last));
  assign w_take     = w_ready && pkt.PKT_VALID;
  assign w_sym_k    = !(w_take || (r_state == S_DATA && r_byte_idx != 3'd5));

  // Byte 0 comes straight from the bus so it can go out the cycle after the handshake
  always_comb begin
    w_byte = pkt.PKT_DATA[47:40];
    if (!w_take) begin
      case (r_byte_idx)
        3'd0:    w_byte = r_pkt[39:32];
        3'd1:    w_byte = r_pkt[31:24];
        3'd2:    w_byte = r_pkt[23:16];
        3'd3:    w_byte = r_pkt[15:8];
        3'd4:    w_byte = r_pkt[7:0];
        default: w_byte = 8'h00;
      endcase
    end
  end

  assign w_enc = enc_8b10b(w_byte, w_sym_k, r_rd ^ r_flip);

`ifdef TPX3_TX_ERR_INJ_EN
  logic r_err_arm;
  logic w_err_use;
  assign w_err_use = w_bnd && !w_sym_k && r_err_arm;
  assign w_line    = w_enc[9:0] ^ {w_err_use, 9'd0};

  always_ff @(posedge CLK) begin
    if (RST)            r_err_arm <= 1'b0;
    else if (w_err_use) r_err_arm <= 1'b0;
    else if (INJECT_ERR) r_err_arm <= 1'b1;
  end
`else
  assign w_line = w_enc[9:0];
`endif

  // r_rd is the RD entering the symbol on the line; r_flip says whether that symbol inverts it
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 4'd0;
      r_byte_idx <= 3'd0;
      r_gap_cnt  <= 4'd0;
      r_pkt      <= 48'd0;
      r_shift    <= K28_5_NEG;
      r_rd       <= 1'b0;
      r_flip     <= 1'b1;
      r_busy     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_bit_cnt <= w_bnd ? 4'd0 : r_bit_cnt + 4'd1;
      if (w_bnd) begin
        r_shift <= w_line;
        r_rd    <= r_rd ^ r_flip;
        r_flip  <= w_enc[10];
        r_busy  <= !w_sym_k;
        if (r_state == S_DATA && r_byte_idx == 3'd5) r_cnt <= r_cnt + 1'b1;
        if (w_take) begin
          r_pkt      <= pkt.PKT_DATA;
          r_state    <= S_DATA;
          r_byte_idx <= 3'd0;
        end else begin
          case (r_state)
            S_DATA: begin
              if (r_byte_idx != 3'd5) r_byte_idx <= r_byte_idx + 3'd1;
              else if (HAS_GAP) begin
                r_state   <= S_GAP;
                r_gap_cnt <= 4'd0;
              end else r_state <= S_IDLE;
            end
            S_GAP: begin
              if (w_gap_last) r_state <= S_IDLE;
              else            r_gap_cnt <= r_gap_cnt + 4'd1;
            end
            default: ;
          endcase
        end
      end else begin
        r_shift <= {r_shift[8:0], 1'b0};
      end
    end
  end

  assign TX_DATA       = r_shift[9];
  assign BUSY          = r_busy;
  assign PKT_CNT       = r_cnt;
  assign pkt.PKT_READY = w_ready;
endmodule

// File: tb/tb_tpx3_tx_emu.sv
// Bench for tpx3_tx_emu: two instances (IDLE_GAP=1 and 0) checked bit by bit against a symbol-queue model.
module tb_tpx3_tx_emu;
  localparam int CW = 16;

  logic CLK = 0;
  logic RST = 1;
  logic ENABLE = 1;
  always #5 CLK = ~CLK;

  tpx3_tx_emu_if ifa ();
  tpx3_tx_emu_if ifb ();

  logic [1:0]    vld = 0;
  logic [47:0]   pdata [2];
  logic [1:0]    inj = 0;
  logic [1:0]    tx, busy;
  logic [CW-1:0] cnt [2];
  wire  [1:0]    rdy = {ifb.PKT_READY, ifa.PKT_READY};

  assign ifa.PKT_VALID = vld[0];
  assign ifb.PKT_VALID = vld[1];
  assign ifa.PKT_DATA  = pdata[0];
  assign ifb.PKT_DATA  = pdata[1];

  tpx3_tx_emu #(.IDLE_GAP(1), .PKT_CNT_WIDTH(CW)) u_g1 (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .pkt(ifa),
    .TX_DATA(tx[0]), .BUSY(busy[0]), .PKT_CNT(cnt[0])
`ifdef TPX3_TX_ERR_INJ_EN
    , .INJECT_ERR(inj[0])
`endif
  );
  tpx3_tx_emu #(.IDLE_GAP(0), .PKT_CNT_WIDTH(CW)) u_g0 (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .pkt(ifb),
    .TX_DATA(tx[1]), .BUSY(busy[1]), .PKT_CNT(cnt[1])
`ifdef TPX3_TX_ERR_INJ_EN
    , .INJECT_ERR(inj[1])
`endif
  );

  int checks = 0, errors = 0, ncyc = 0;
  // model: symbol on the line, pending bytes (nb<6) and pending gap commas
  int            bc [2], nb [2], gl [2];
  logic [9:0]    line [2];
  bit            mdata [2], mlast [2], mrd [2], marm [2], hs [2];
  logic [47:0]   mpkt [2];
  logic [CW-1:0] mcnt [2];
  // stimulus driver and observed statistics
  int taken [2], target [2];
  bit rnd_vld = 0, fixed = 0;
  int brun [2], bmax [2], hsn [2], hlast [2], gmin [2], gmax [2];
  logic [9:0] kneg = 10'b0011111010;

  function automatic int gapof(input int u);
    return (u == 0) ? 1 : 0;
  endfunction

  function automatic logic [5:0] t6(input logic [4:0] x);
    logic [5:0] tab [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
      6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100,
      6'b011100, 6'b010111, 6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010,
      6'b011010, 6'b111010, 6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
      6'b011110, 6'b101011};
    return tab[x];
  endfunction

  function automatic logic [3:0] t4(input logic [2:0] y);
    logic [3:0] tab [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    return tab[y];
  endfunction

  // RD- column plus the rule "invert under RD+ if unbalanced or D.07 / D.x.3"
  function automatic logic [9:0] enc(input logic [7:0] d, input bit k, input bit rd);
    logic [5:0] c6; logic [3:0] c4; bit rd6; int x, y;
    if (k) return rd ? 10'b1100000101 : 10'b0011111010;
    x = int'(d[4:0]); y = int'(d[7:5]);
    c6 = t6(d[4:0]);
    if (rd && ($countones(c6) != 3 || x == 7)) c6 = ~c6;
    rd6 = rd ^ ($countones(c6) != 3);
    if (y == 7 && ((!rd6 && (x == 17 || x == 18 || x == 20)) || (rd6 && (x == 11 || x == 13 || x == 14))))
      c4 = 4'b0111;
    else c4 = t4(d[7:5]);
    if (rd6 && ($countones(c4) != 2 || y == 3)) c4 = ~c4;
    return {c6, c4};
  endfunction

  task automatic mreset(input int u);
    bc[u] = 0; nb[u] = 6; gl[u] = 0; line[u] = 10'b0011111010; mrd[u] = 1;
    mdata[u] = 0; mlast[u] = 0; marm[u] = 0; mcnt[u] = '0; mpkt[u] = '0;
  endtask

  task automatic chk(input string tag, input int u, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s u%0d observed=%0h expected=%0h", tag, u, obs, exp);
    end
  endtask

  task automatic step(input int u);
    logic [9:0] code; logic [7:0] b; bit k, used;
    hs[u] = 0; used = 0;
    if (RST) begin mreset(u); return; end
    if (bc[u] == 9) begin
      if (mlast[u]) mcnt[u]++;
      if (nb[u] == 6 && gl[u] == 0 && ENABLE && vld[u]) begin
        mpkt[u] = pdata[u]; nb[u] = 0; gl[u] = gapof(u); hs[u] = 1;
      end
      k = 1; b = 8'h00; mlast[u] = 0;
      if (nb[u] < 6) begin
        b = mpkt[u][47-8*nb[u] -: 8]; k = 0; mlast[u] = (nb[u] == 5); nb[u]++;
      end else if (gl[u] > 0) gl[u]--;
      code = enc(b, k, mrd[u]);
      mrd[u] = mrd[u] ^ ($countones(code) != 5);
      line[u] = code; mdata[u] = !k; bc[u] = 0;
      if (!k && marm[u]) begin line[u][9] = ~line[u][9]; marm[u] = 0; used = 1; end
    end else bc[u]++;
    if (!used && inj[u]) marm[u] = 1;
  endtask

  task automatic cyc();
    #1;
    for (int u = 0; u < 2; u++) begin
      bit er;
      er = !RST && bc[u] == 9 && ENABLE && nb[u] == 6 && gl[u] == 0;
      chk("tx", u, tx[u], line[u][9-bc[u]]);
      chk("ready", u, rdy[u], er);
      chk("busy", u, busy[u], mdata[u]);
      chk("cnt", u, cnt[u], mcnt[u]);
      if (busy[u]) begin brun[u]++; if (brun[u] > bmax[u]) bmax[u] = brun[u]; end
      else brun[u] = 0;
      if (rdy[u] && vld[u]) begin
        hsn[u]++;
        if (hlast[u] >= 0) begin
          if (ncyc - hlast[u] < gmin[u]) gmin[u] = ncyc - hlast[u];
          if (ncyc - hlast[u] > gmax[u]) gmax[u] = ncyc - hlast[u];
        end
        hlast[u] = ncyc;
      end
      step(u);
    end
    ncyc++;
    @(posedge CLK); #1;
    for (int u = 0; u < 2; u++) begin
      if (hs[u]) taken[u]++;
      vld[u] = (taken[u] < target[u]) && (!rnd_vld || $urandom_range(0, 1) == 1);
      if (!fixed) pdata[u] = {16'($urandom), $urandom};
    end
  endtask

  task automatic clr_stats();
    for (int u = 0; u < 2; u++) begin
      brun[u] = 0; bmax[u] = 0; hsn[u] = 0; hlast[u] = -1; gmin[u] = 1000000; gmax[u] = 0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic send_and_wait(input string tag);
    int w;
    for (int u = 0; u < 2; u++) target[u] = taken[u] + 1;
    w = 0;
    while (taken[0] < target[0] && w < 40) begin cyc(); w++; end
    chk(tag, 0, taken[0] >= target[0], 1);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      mreset(u); taken[u] = 0; target[u] = 0; pdata[u] = '0;
    end
    clr_stats();
    @(posedge CLK); #1;
    run(3);
    RST = 0;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_tx", u, tx[u], 0);
      chk("rst_ready", u, rdy[u], 0);
      chk("rst_busy", u, busy[u], 0);
      chk("rst_cnt", u, cnt[u], 0);
    end
    // idle commas alternate RD
    run(100);

    // single directed packet
    clr_stats();
    fixed = 1;
    for (int u = 0; u < 2; u++) pdata[u] = 48'hA55A00FF3C81;
    send_and_wait("hs_single");
    run(100);
    fixed = 0;
    for (int u = 0; u < 2; u++) begin
      chk("single_cnt", u, cnt[u], 1);
      chk("single_busy", u, bmax[u], 60);
      chk("single_hs", u, hsn[u], 1);
    end

    // back-to-back with PKT_VALID held
    clr_stats();
    for (int u = 0; u < 2; u++) target[u] = taken[u] + 4;
    run(330);
    chk("b2b_cnt", 0, cnt[0], 5);
    chk("b2b_cnt", 1, cnt[1], 5);
    chk("b2b_hs", 0, hsn[0], 4);
    chk("b2b_hs", 1, hsn[1], 4);
    chk("b2b_contig", 1, bmax[1], 240);
    chk("b2b_contig", 0, bmax[0], 60);
    chk("b2b_gap_min", 1, gmin[1], 60);
    chk("b2b_gap_max", 1, gmax[1], 60);
    chk("b2b_gap_min", 0, gmin[0], 70);
    chk("b2b_gap_max", 0, gmax[0], 70);

    // ENABLE dropped during byte 2
    send_and_wait("hs_en");
    run(25);
    ENABLE = 0;
    clr_stats();
    for (int u = 0; u < 2; u++) target[u] = taken[u] + 1;
    run(150);
    for (int u = 0; u < 2; u++) begin
      chk("en_cnt", u, cnt[u], 6);
      chk("en_hs", u, hsn[u], 0);
    end
    ENABLE = 1;
    run(100);
    for (int u = 0; u < 2; u++) begin
      chk("en_resume_cnt", u, cnt[u], 7);
      chk("en_resume_hs", u, hsn[u], 1);
    end

    // reset during byte 3
    send_and_wait("hs_rst");
    run(35);
    RST = 1;
    cyc();
    RST = 0;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("midrst_cnt", u, cnt[u], 0);
      chk("midrst_busy", u, busy[u], 0);
    end
    for (int i = 0; i < 10; i++) begin
      #1 chk("midrst_comma", 0, tx[0], kneg[9-i]);
      cyc();
    end

    // randomized traffic with random ENABLE and PKT_VALID
    rnd_vld = 1;
    for (int u = 0; u < 2; u++) target[u] = taken[u] + 20;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if ($urandom_range(0, 49) == 0) ENABLE = ~ENABLE;
    end
    rnd_vld = 0;
    ENABLE = 1;
    for (int u = 0; u < 2; u++) target[u] = taken[u];
    run(200);

`ifdef TPX3_TX_ERR_INJ_EN
    // arm during a comma, then one packet: first data symbol goes out with bit a flipped
    while (bc[0] != 3) cyc();
    inj = 2'b11;
    cyc();
    inj = 2'b00;
    for (int u = 0; u < 2; u++) chk("inj_armed", u, marm[u], 1);
    send_and_wait("hs_inj");
    run(100);
    for (int u = 0; u < 2; u++) chk("inj_consumed", u, marm[u], 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
